vga_sdram_reader: RTL and testbench



---
 rtl/vga_sdram_reader.sv | 111 +++++++++++
 tb/tb_vga_sdram_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sdram_reader.sv
`default_nettype none
// ============================================================================
// Module  : vga_sdram_reader
// Brief   : VGA timing generator that pops RGB565 pixels from the SDRAM read
//           FIFO one clock ahead of each active pixel, with frame gating.
// Rev     : 1.0  initial release
// ============================================================================
module vga_sdram_reader #(
  parameter int H_SYNC  = 136,
  parameter int H_BACK  = 160,
  parameter int H_VALID = 1024,
  parameter int H_FRONT = 24,
  parameter int V_SYNC  = 6,
  parameter int V_BACK  = 29,
  parameter int V_VALID = 768,
  parameter int V_FRONT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_rd_ready,
  input  logic        fifo_empty,
  input  logic [15:0] sdram_rd_data,
  output logic        sdram_rd_req,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        underflow
);

  localparam logic [10:0] c_h_total  = 11'(H_SYNC + H_BACK + H_VALID + H_FRONT);
  localparam logic [10:0] c_h_sync   = 11'(H_SYNC);
  localparam logic [10:0] c_ha       = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] c_ha_end   = 11'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0]  c_v_total  = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
  localparam logic [9:0]  c_v_sync   = 10'(V_SYNC);
  localparam logic [9:0]  c_va       = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  c_va_end   = 10'(V_SYNC + V_BACK + V_VALID);

  logic [10:0] r_cnt_h;
  logic [9:0]  r_cnt_v;
  logic        r_frame_ok;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [15:0] r_rgb;
  logic        r_frame_start;
  logic        r_underflow;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_origin;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_req;
  logic        w_active;
  logic        w_rd_req;
  logic [10:0] w_cnt_h_next;

  assign w_h_last     = (r_cnt_h == c_h_total - 11'd1);
  assign w_v_last     = (r_cnt_v == c_v_total - 10'd1);
  assign w_origin     = (r_cnt_h == 11'd0) && (r_cnt_v == 10'd0);
  assign w_h_act      = (r_cnt_h >= c_ha) && (r_cnt_h < c_ha_end);
  assign w_v_act      = (r_cnt_v >= c_va) && (r_cnt_v < c_va_end);
  assign w_active     = w_h_act && w_v_act;
  // Request window leads the active window by one clock (non-show-ahead FIFO).
  assign w_cnt_h_next = r_cnt_h + 11'd1;
  assign w_h_req      = (w_cnt_h_next >= c_ha) && (w_cnt_h_next < c_ha_end);
  assign w_rd_req     = r_frame_ok && w_v_act && w_h_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_h       <= '0;
      r_cnt_v       <= '0;
      r_frame_ok    <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_cnt_h <= w_h_last ? 11'd0 : w_cnt_h_next;
      if (w_h_last) begin
        r_cnt_v <= w_v_last ? 10'd0 : r_cnt_v + 10'd1;
      end
      if (w_origin) begin
        r_frame_ok <= sdram_rd_ready;
      end
      r_hs          <= !(r_cnt_h < c_h_sync);
      r_vs          <= !(r_cnt_v < c_v_sync);
      r_de          <= w_active;
      r_rgb         <= (w_active && r_frame_ok) ? sdram_rd_data : 16'h0000;
      r_frame_start <= w_origin;
      if (w_rd_req && fifo_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign sdram_rd_req = w_rd_req;
  assign frame_start  = r_frame_start;
  assign vga_hs       = r_hs;
  assign vga_vs       = r_vs;
  assign vga_de       = r_de;
  assign vga_rgb      = r_rgb;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_sdram_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sdram_reader
// Brief   : Randomized self-checking bench for vga_sdram_reader on a reduced
//           10x6 raster, compared against a frame-position reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_sdram_reader;

  localparam int HT = 10;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdram_rd_ready = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [15:0] sdram_rd_data = 16'h0;
  logic        sdram_rd_req;
  logic        frame_start;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [15:0] vga_rgb;
  logic        underflow;

  vga_sdram_reader #(
    .H_SYNC(2), .H_BACK(2), .H_VALID(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .sdram_rd_ready(sdram_rd_ready), .fifo_empty(fifo_empty),
    .sdram_rd_data(sdram_rd_data), .sdram_rd_req(sdram_rd_req),
    .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .vga_rgb(vga_rgb), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  // Reference model: raster position within the frame, frame gating, pixel queue.
  int          m_pos = 0;
  logic        m_ok = 1'b0;
  logic        m_uf = 1'b0;
  logic        m_req_prev = 1'b0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  logic [15:0] e_rgb = 16'h0;
  logic [15:0] pix_q[$];

  function automatic logic is_act(input int pos);
    int h = pos % HT;
    int v = pos / HT;
    return (h >= 4 && h <= 7 && v >= 2 && v <= 4);
  endfunction

  function automatic logic is_req(input int pos, input logic ok);
    int h = pos % HT;
    int v = pos / HT;
    return ok && (h >= 3 && h <= 6 && v >= 2 && v <= 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_ok <= 1'b0; m_uf <= 1'b0; m_req_prev <= 1'b0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0; e_rgb <= 16'h0;
      pix_q.delete();
    end else begin : model_step
      logic [15:0] px;
      logic        rq;
      rq = is_req(m_pos, m_ok);
      if (m_req_prev) pix_q.push_back(sdram_rd_data);
      px = 16'h0;
      if (is_act(m_pos) && m_ok) px = (pix_q.size() > 0) ? pix_q.pop_front() : 16'hDEAD;
      e_rgb <= px;
      e_hs  <= !((m_pos % HT) < 2);
      e_vs  <= !((m_pos / HT) < 1);
      e_de  <= is_act(m_pos);
      e_fs  <= (m_pos == 0);
      if (m_pos == 0) m_ok <= sdram_rd_ready;
      if (rq && fifo_empty) m_uf <= 1'b1;
      m_req_prev <= rq;
      m_pos <= (m_pos + 1) % FT;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hs", 32'(vga_hs), 32'(e_hs));
      chk("vs", 32'(vga_vs), 32'(e_vs));
      chk("de", 32'(vga_de), 32'(e_de));
      chk("fs", 32'(frame_start), 32'(e_fs));
      chk("rgb", 32'(vga_rgb), 32'(e_rgb));
      chk("req", 32'(sdram_rd_req), 32'(is_req(m_pos, m_ok)));
      chk("uf", 32'(underflow), 32'(m_uf));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1 sdram_rd_data = 16'($urandom);
    end
  end

  int c_req, c_fs, c_hsl, c_vsl, c_de, c_rgbnz;

  task automatic run(input int n);
    c_req = 0; c_fs = 0; c_hsl = 0; c_vsl = 0; c_de = 0; c_rgbnz = 0;
    repeat (n) begin
      @(negedge clk);
      c_req += int'(sdram_rd_req);
      c_fs  += int'(frame_start);
      c_hsl += int'(!vga_hs);
      c_vsl += int'(!vga_vs);
      c_de  += int'(vga_de);
      c_rgbnz += int'(vga_rgb != 16'h0);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_de", 32'(vga_de), 32'd0);
    chk("rst_req", 32'(sdram_rd_req), 32'd0);
    chk("rst_rgb", 32'(vga_rgb), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    sdram_rd_ready = 1'b1;
    rst = 1'b0;

    // Three ready frames: timing counts and 36 requests.
    run(3 * FT);
    chk("req_3frames", 32'(c_req), 32'd36);
    chk("fs_3frames", 32'(c_fs), 32'd3);
    chk("hs_low", 32'(c_hsl), 32'd36);
    chk("vs_low", 32'(c_vsl), 32'd30);
    chk("de_high", 32'(c_de), 32'd36);

    // Not ready at origin, raised mid-frame.
    sdram_rd_ready = 1'b0;
    run(30);
    sdram_rd_ready = 1'b1;
    begin : nr_frame
      int r0, nz0;
      r0 = c_req; nz0 = c_rgbnz;
      run(30);
      chk("req_notready", 32'(r0 + c_req), 32'd0);
      chk("rgb_notready", 32'(nz0 + c_rgbnz), 32'd0);
    end
    run(FT);
    chk("req_next_frame", 32'(c_req), 32'd12);

    // Underflow on the 5th request of the frame (position 33).
    run(33);
    fifo_empty = 1'b1;
    chk("uf_before", 32'(underflow), 32'd0);
    run(1);
    fifo_empty = 1'b0;
    chk("uf_after", 32'(underflow), 32'd1);
    run(2 * FT);
    chk("uf_sticky", 32'(underflow), 32'd1);

    // Mid-frame asynchronous reset at cnt_h=5, cnt_v=3.
    run(((35 - (m_pos % FT)) + FT) % FT);
    #2 rst = 1'b1;
    #1;
    chk("arst_hs", 32'(vga_hs), 32'd1);
    chk("arst_vs", 32'(vga_vs), 32'd1);
    chk("arst_de", 32'(vga_de), 32'd0);
    chk("arst_rgb", 32'(vga_rgb), 32'd0);
    chk("arst_req", 32'(sdram_rd_req), 32'd0);
    chk("arst_uf", 32'(underflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("fs_after_rst", 32'(frame_start), 32'd1);

    // Randomized readiness and occasional empty FIFO over several frames.
    repeat (6) begin
      sdram_rd_ready = 1'($urandom_range(0, 1));
      repeat (FT) begin
        fifo_empty = ($urandom_range(0, 15) == 0);
        run(1);
      end
    end
    fifo_empty = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
